// File: rtl/gnt_event_encoder.sv
// gnt_event_encoder: turns one-hot arbiter grants into timestamped AER packets behind a show-ahead FIFO
module gnt_event_encoder #(
    parameter int NUM_REQUESTS = 256,
    parameter int ADDR_W       = $clog2(NUM_REQUESTS),
    parameter int TS_W         = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DROP_W       = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQUESTS-1:0]       gnt_i,
    output logic                          ev_valid_o,
    input  logic                          ev_ready_i,
    output logic [ADDR_W-1:0]             ev_addr_o,
    output logic [TS_W-1:0]               ev_ts_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_lvl_o,
    output logic [DROP_W-1:0]             drop_cnt_o,
    output logic                          multi_err_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [NUM_REQUESTS-1:0] gnt_q;
    logic [TS_W-1:0]         ts_cnt;
    logic [ADDR_W-1:0]       mem_addr [FIFO_DEPTH];
    logic [TS_W-1:0]         mem_ts   [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr, rd_next;
    logic [LVL_W-1:0]        lvl_next;
    logic [ADDR_W-1:0]       enc_addr;
    logic                    new_ev, multi_hot, full, pop, do_push, drop;

    // lowest set grant bit wins, so a multi-hot vector still encodes deterministically
    always_comb begin
        enc_addr = '0;
        for (int i = NUM_REQUESTS - 1; i >= 0; i--)
            if (gnt_i[i]) enc_addr = ADDR_W'(i);
    end

    assign new_ev     = (gnt_i != '0) && (gnt_i != gnt_q);
    assign multi_hot  = (gnt_i & (gnt_i - NUM_REQUESTS'(1))) != '0;
    assign full       = fifo_lvl_o == LVL_W'(FIFO_DEPTH);
    assign ev_valid_o = fifo_lvl_o != '0;
    assign pop        = ev_valid_o && ev_ready_i;
    assign do_push    = new_ev && (!full || pop);
    assign drop       = new_ev && full && !pop;
    assign rd_next    = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    assign lvl_next   = fifo_lvl_o + LVL_W'(do_push) - LVL_W'(pop);

    // packet storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= enc_addr;
            mem_ts[wr_ptr]   <= ts_cnt;
        end
    end

    // control state; outputs register the next head so they hold the last popped packet when empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q       <= '0;
            ts_cnt      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_lvl_o  <= '0;
            drop_cnt_o  <= '0;
            multi_err_o <= 1'b0;
            ev_addr_o   <= '0;
            ev_ts_o     <= '0;
        end else begin
            gnt_q      <= gnt_i;
            ts_cnt     <= ts_cnt + TS_W'(1);
            rd_ptr     <= rd_next;
            fifo_lvl_o <= lvl_next;
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            if (multi_hot) multi_err_o <= 1'b1;
            if (lvl_next != '0) begin
                ev_addr_o <= (do_push && rd_next == wr_ptr) ? enc_addr : mem_addr[rd_next];
                ev_ts_o   <= (do_push && rd_next == wr_ptr) ? ts_cnt : mem_ts[rd_next];
            end
        end
    end
endmodule
